uart_cfg_top: RTL

Runtime-configurable UART core: a parametrised successor to the fixed-format UART top level. Adds a runtime baud divisor, selectable parity (none/even/odd), 1 or 2 stop bits, false-start rejection and sticky receive error flags (framing, parity, overrun). It sits between the board UART pins and the gripper command parser, with byte FIFOs on both directions, and reuses the team's existing `fifo` module.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/fifo.sv | 45 ++++
 rtl/uart_baud_div.sv | 25 ++
 rtl/uart_cfg_top.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the runtime-configurable UART: parity modes, FSM states
// and the default oversampling ratio.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Mode 2'b11 is deliberately treated as "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/fifo.sv
// Byte FIFO of 2^W entries; a push into a full FIFO or a pop from an empty one is
// ignored, even when the opposite operation happens in the same cycle.
module fifo #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         rd_i,
    input  logic         wr_i,
    input  logic [B-1:0] w_data_i,
    output logic         empty_o,
    output logic         full_o,
    output logic [B-1:0] r_data_o
);

    logic [B-1:0] mem_q [2**W];
    logic [W:0]   wp_q, wp_d, rp_q, rp_d;
    logic         do_wr, do_rd;

    always_comb begin
        empty_o  = (wp_q == rp_q);
        full_o   = (wp_q[W] != rp_q[W]) && (wp_q[W-1:0] == rp_q[W-1:0]);
        do_wr    = wr_i && !full_o;
        do_rd    = rd_i && !empty_o;
        wp_d     = do_wr ? wp_q + 1'b1 : wp_q;
        rp_d     = do_rd ? rp_q + 1'b1 : rp_q;
        r_data_o = mem_q[rp_q[W-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wp_q[W-1:0]] <= w_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

endmodule

// File: rtl/uart_baud_div.sv
// Runtime-divisor baud tick generator: one-cycle tick every div_i clocks (min 2).
module uart_baud_div #(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                restart_i,
    input  logic [DIV_BITS-1:0] div_i,
    output logic                tick_o
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d, lim;

    always_comb begin
        lim    = (div_i < DIV_BITS'(2)) ? DIV_BITS'(1) : div_i - DIV_BITS'(1);
        tick_o = (cnt_q == lim);
        cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + DIV_BITS'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cfg_top.sv
// Runtime-configurable UART: baud divisor, parity and stop bits latched by cfg_load
// while idle; byte FIFOs on both directions and sticky RX error flags.
module uart_cfg_top
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int unsigned DIV_BITS    = 16,
    parameter int unsigned DIV_DEFAULT = 651,
    parameter int unsigned FIFO_EXP    = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DIV_BITS-1:0]  cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 cfg_load,
    input  logic                 write_uart,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic                 read_uart,
    input  logic                 rx_data_in,
    input  logic                 err_clear,
    output logic                 tx_data_out,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 rx_full,
    output logic                 rx_empty,
    output logic                 rx_err_frame,
    output logic                 rx_err_parity,
    output logic                 rx_err_overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] S_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] S_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic [DIV_BITS-1:0]  div_q;
    logic [1:0]           par_q;
    logic                 stop2_q, cfg_accept, tick;

    tx_state_e            tx_state_q;
    logic [CW-1:0]        tx_s_q;
    logic [NW-1:0]        tx_n_q;
    logic [DATA_BITS-1:0] tx_shift_q, tx_head;
    logic                 tx_q, tx_par_q, tx_stop2nd_q, tx_pop, tx_par_next;

    rx_state_e            rx_state_q;
    logic [CW-1:0]        rx_s_q;
    logic [NW-1:0]        rx_n_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_meta_q, rx_sync_q, rx_parbit_q, rx_stop_q, rx_done_q;
    logic                 rx_push, rx_par_bad;
    logic                 frame_q, frame_d, parity_q, parity_d, ovr_q, ovr_d;

    always_comb begin
        busy        = (tx_state_q != TX_IDLE) || (rx_state_q != RX_IDLE) || !tx_empty;
        cfg_accept  = cfg_load && !busy;
        tx_par_next = (^tx_head) ^ (par_q == PAR_ODD);
        tx_pop      = tick && !tx_empty &&
                      ((tx_state_q == TX_IDLE) ||
                       ((tx_state_q == TX_STOP) && (tx_s_q == S_LAST) &&
                        (!stop2_q || tx_stop2nd_q)));
        rx_par_bad  = par_enabled(par_q) &&
                      (((^rx_shift_q) ^ rx_parbit_q) != (par_q == PAR_ODD));
        rx_push     = rx_done_q && rx_stop_q && !rx_full;
        // A new error in the same cycle as err_clear keeps the flag set.
        frame_d     = (rx_done_q && !rx_stop_q) || (frame_q && !err_clear);
        parity_d    = (rx_done_q && rx_stop_q && rx_par_bad) || (parity_q && !err_clear);
        ovr_d       = (rx_done_q && rx_stop_q && rx_full) || (ovr_q && !err_clear);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q   <= DIV_BITS'(DIV_DEFAULT);
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
        end else if (cfg_accept) begin
            div_q   <= cfg_div;
            par_q   <= cfg_parity;
            stop2_q <= cfg_stop2;
        end
    end

    uart_baud_div #(.DIV_BITS(DIV_BITS)) u_baud (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .restart_i (cfg_accept),
        .div_i     (div_q),
        .tick_o    (tick)
    );

    fifo #(.B(DATA_BITS), .W(FIFO_EXP)) u_tx_fifo (
        .clk_i    (CLK),
        .reset_i  (RESET),
        .rd_i     (tx_pop),
        .wr_i     (write_uart),
        .w_data_i (write_data),
        .empty_o  (tx_empty),
        .full_o   (tx_full),
        .r_data_o (tx_head)
    );

    fifo #(.B(DATA_BITS), .W(FIFO_EXP)) u_rx_fifo (
        .clk_i    (CLK),
        .reset_i  (RESET),
        .rd_i     (read_uart),
        .wr_i     (rx_push),
        .w_data_i (rx_shift_q),
        .empty_o  (rx_empty),
        .full_o   (rx_full),
        .r_data_o (read_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q   <= TX_IDLE;
            tx_q         <= 1'b1;
            tx_s_q       <= '0;
            tx_n_q       <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_stop2nd_q <= 1'b0;
        end else begin
            if (tx_pop) begin
                tx_state_q <= TX_START;
                tx_q       <= 1'b0;
                tx_s_q     <= '0;
                tx_shift_q <= tx_head;
                tx_par_q   <= tx_par_next;
            end else if (tick) begin
                tx_s_q <= (tx_s_q == S_LAST) ? '0 : tx_s_q + 1'b1;
                if (tx_s_q == S_LAST) begin
                    unique case (tx_state_q)
                        TX_START: begin
                            tx_state_q <= TX_DATA;
                            tx_n_q     <= '0;
                            tx_q       <= tx_shift_q[0];
                        end
                        TX_DATA: begin
                            if (tx_n_q == N_LAST) begin
                                tx_state_q   <= par_enabled(par_q) ? TX_PARITY : TX_STOP;
                                tx_q         <= par_enabled(par_q) ? tx_par_q : 1'b1;
                                tx_stop2nd_q <= 1'b0;
                            end else begin
                                tx_n_q     <= tx_n_q + 1'b1;
                                tx_shift_q <= tx_shift_q >> 1;
                                tx_q       <= tx_shift_q[1];
                            end
                        end
                        TX_PARITY: begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end
                        TX_STOP: begin
                            if (stop2_q && !tx_stop2nd_q) tx_stop2nd_q <= 1'b1;
                            else                          tx_state_q   <= TX_IDLE;
                        end
                        default: begin
                            tx_state_q <= TX_IDLE;
                            tx_q       <= 1'b1;
                        end
                    endcase
                end
                if (tx_state_q == TX_IDLE) tx_s_q <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_s_q      <= '0;
            rx_n_q      <= '0;
            rx_shift_q  <= '0;
            rx_parbit_q <= 1'b0;
            rx_stop_q   <= 1'b1;
            rx_done_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_data_in;
            rx_sync_q <= rx_meta_q;
            rx_done_q <= 1'b0;
            if (tick) begin
                rx_s_q <= rx_s_q + 1'b1;
                unique case (rx_state_q)
                    RX_IDLE: begin
                        rx_s_q <= '0;
                        if (!rx_sync_q) rx_state_q <= RX_START;
                    end
                    RX_START: if (rx_s_q == S_HALF) begin
                        rx_s_q     <= '0;
                        rx_n_q     <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (rx_s_q == S_LAST) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_n_q     <= rx_n_q + 1'b1;
                        if (rx_n_q == N_LAST)
                            rx_state_q <= par_enabled(par_q) ? RX_PARITY : RX_STOP;
                    end
                    RX_PARITY: if (rx_s_q == S_LAST) begin
                        rx_parbit_q <= rx_sync_q;
                        rx_state_q  <= RX_STOP;
                    end
                    RX_STOP: if (rx_s_q == S_LAST) begin
                        rx_stop_q  <= rx_sync_q;
                        rx_done_q  <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_q  <= 1'b0;
            parity_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            parity_q <= parity_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        tx_data_out    = tx_q;
        rx_err_frame   = frame_q;
        rx_err_parity  = parity_q;
        rx_err_overrun = ovr_q;
    end

endmodule
